// File: rtl/clb_pkg.sv
// Shared types and constants for the CLB configuration loader.
// The CRC-8 step function is used only when CLB_CFG_CRC_EN is defined.
package clb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK,
        DONE,
        ERROR
    } cfg_state_e;

    localparam logic [7:0] CLB_CFG_MAGIC = 8'hA5;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    // One MSB-first step of CRC-8 for a single incoming bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic feedback;
        feedback  = crc[7] ^ bit_in;
        crc8_step = {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/clb_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle
// rising and falling edge pulses derived in the clk domain.
module clb_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: header check, LUT word deserialisation, one write per word.
// Define CLB_CFG_CRC_EN to require a trailing CRC-8 over header and data bits.
module clb_cfg_loader
    import clb_pkg::*;
#(
    parameter int unsigned NUM_LUTS = 4,
    parameter int unsigned LUT_BITS = 16,
    parameter logic [7:0]  MAGIC    = CLB_CFG_MAGIC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        cfg_cs_n_i,
    input  logic                        cfg_sclk_i,
    input  logic                        cfg_sdat_i,
    output logic                        cfg_we_o,
    output logic [$clog2(NUM_LUTS)-1:0] cfg_addr_o,
    output logic [LUT_BITS-1:0]         cfg_data_o,
    output logic                        cfg_busy_o,
    output logic                        cfg_done_o,
    output logic                        cfg_err_o
);

    localparam int unsigned AW = $clog2(NUM_LUTS);
    localparam int unsigned BW = $clog2(LUT_BITS);

    localparam logic [BW-1:0] BYTE_LAST     = BW'(7);
    localparam logic [BW-1:0] WORD_BIT_LAST = BW'(LUT_BITS - 1);
    localparam logic [AW-1:0] WORD_LAST     = AW'(NUM_LUTS - 1);

    cfg_state_e state;
    cfg_state_e state_next;

    logic cs_n_sync;
    logic cs_rise;
    logic cs_fall;
    logic sclk_sync;
    logic sclk_rise;
    logic sclk_fall;
    logic sdat_meta;
    logic sdat_sync;

    logic [LUT_BITS-1:0] shreg;
    logic [LUT_BITS-1:0] shift_next;
    logic [BW-1:0]       bit_cnt;
    logic [AW-1:0]       word_cnt;

    logic abort;
    logic start;
    logic take_bit;
    logic bit_last;
    logic word_end;
    logic set_done;
    logic set_err;

    clb_sync_edge u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cfg_cs_n_i),
        .sync  (cs_n_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    clb_sync_edge u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cfg_sclk_i),
        .sync  (sclk_sync),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Data is only sampled on sclk edges, so no edge detection is needed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdat_meta <= 1'b0;
            sdat_sync <= 1'b0;
        end else begin
            sdat_meta <= cfg_sdat_i;
            sdat_sync <= sdat_meta;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{cs_rise, sclk_sync, sclk_fall, shreg[LUT_BITS-1]};

`ifdef CLB_CFG_CRC_EN
    logic [7:0] crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (start) begin
            crc <= '0;
        end else if (take_bit && state != CHECK) begin
            crc <= crc8_step(crc, sdat_sync);
        end
    end
`endif

    // Abort has priority over any sclk edge seen in the same cycle.
    assign abort = cs_n_sync | ~ena;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        take_bit   = 1'b0;
        bit_last   = 1'b0;
        word_end   = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        shift_next = {shreg[LUT_BITS-2:0], sdat_sync};

        case (state)
            IDLE: begin
                if (ena && cs_fall) begin
                    state_next = HEADER;
                    start      = 1'b1;
                end
            end
            HEADER: begin
                if (abort) begin
                    state_next = ERROR;
                    set_err    = 1'b1;
                end else if (sclk_rise) begin
                    take_bit = 1'b1;
                    if (bit_cnt == BYTE_LAST) begin
                        bit_last = 1'b1;
                        if (shift_next[7:0] == MAGIC) begin
                            state_next = DATA;
                        end else begin
                            state_next = ERROR;
                            set_err    = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (abort) begin
                    state_next = ERROR;
                    set_err    = 1'b1;
                end else if (sclk_rise) begin
                    take_bit = 1'b1;
                    if (bit_cnt == WORD_BIT_LAST) begin
                        bit_last = 1'b1;
                        word_end = 1'b1;
                        if (word_cnt == WORD_LAST) begin
                            state_next = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (abort) begin
                    state_next = ERROR;
                    set_err    = 1'b1;
                end else begin
`ifdef CLB_CFG_CRC_EN
                    if (sclk_rise) begin
                        take_bit = 1'b1;
                        if (bit_cnt == BYTE_LAST) begin
                            bit_last = 1'b1;
                            if (shift_next[7:0] == crc) begin
                                state_next = DONE;
                                set_done   = 1'b1;
                            end else begin
                                state_next = ERROR;
                                set_err    = 1'b1;
                            end
                        end
                    end
`else
                    state_next = DONE;
                    set_done   = 1'b1;
`endif
                end
            end
            DONE, ERROR: begin
                if (cs_n_sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            cfg_we_o   <= 1'b0;
            cfg_addr_o <= '0;
            cfg_data_o <= '0;
            cfg_done_o <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            cfg_we_o <= word_end;
            if (start) begin
                shreg      <= '0;
                bit_cnt    <= '0;
                word_cnt   <= '0;
                cfg_done_o <= 1'b0;
                cfg_err_o  <= 1'b0;
            end
            if (take_bit) begin
                shreg   <= shift_next;
                bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
            end
            if (word_end) begin
                cfg_addr_o <= word_cnt;
                cfg_data_o <= shift_next;
                if (word_cnt != WORD_LAST) begin
                    word_cnt <= word_cnt + AW'(1);
                end
            end
            if (set_done) begin
                cfg_done_o <= 1'b1;
            end
            if (set_err) begin
                cfg_err_o <= 1'b1;
            end
        end
    end

    assign cfg_busy_o = (state == HEADER) || (state == DATA) || (state == CHECK);

endmodule
